// File: rtl/vga_sync_gen_if.sv
// Timing bundle produced by vga_sync_gen: position counters plus sync/active/frame strobes.
// The master drives it (the generator); the slave is the downstream pixel stage.
interface vga_sync_gen_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       frame_start;

  modport master (output hc, output vc, output hsync, output vsync, output active, output frame_start);
  modport slave  (input  hc, input  vc, input  hsync, input  vsync, input  active, input  frame_start);
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: h/v counters with registered, cycle-aligned sync/active/frame flags.
// Optional macro VGA_CLKDIV_EN: advance only every second i_clk edge (for a 50 MHz i_clk).
module vga_sync_gen #(
  parameter int unsigned hpixels = 800,
  parameter int unsigned vlines  = 521,
  parameter int unsigned hpulse  = 96,
  parameter int unsigned vpulse  = 2,
  parameter int unsigned hbp     = 144,
  parameter int unsigned hfp     = 784,
  parameter int unsigned vbp     = 31,
  parameter int unsigned vfp     = 511
) (
  input  logic           i_clk,
  input  logic           i_rst,
  vga_sync_gen_if.master vga_o
);

  localparam logic [9:0] H_LAST  = 10'(hpixels - 1);
  localparam logic [9:0] V_LAST  = 10'(vlines - 1);
  localparam logic [9:0] H_PULSE = 10'(hpulse);
  localparam logic [9:0] V_PULSE = 10'(vpulse);
  localparam logic [9:0] H_BP    = 10'(hbp);
  localparam logic [9:0] H_FP    = 10'(hfp);
  localparam logic [9:0] V_BP    = 10'(vbp);
  localparam logic [9:0] V_FP    = 10'(vfp);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       fs_q, fs_d;
  logic       adv;

`ifdef VGA_CLKDIV_EN
  logic tog_q;

  // Toggle is 0 on the first edge after reset, so the first advance lands on the second edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tog_q <= 1'b0;
    else       tog_q <= ~tog_q;
  end

  assign adv = tog_q;
`else
  assign adv = 1'b1;
`endif

  // Flags are decoded from the next counter values so they line up with the counters they describe.
  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    fs_d = 1'b0;
    if (hc_q == H_LAST) begin
      hc_d = 10'd0;
      if (vc_q == V_LAST) begin
        vc_d = 10'd0;
        fs_d = 1'b1;
      end else begin
        vc_d = vc_q + 10'd1;
      end
    end
    hsync_d  = (hc_d >= H_PULSE);
    vsync_d  = (vc_d >= V_PULSE);
    active_d = (hc_d >= H_BP) && (hc_d < H_FP) && (vc_d >= V_BP) && (vc_d < V_FP);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hc_q     <= 10'd0;
      vc_q     <= 10'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
    end else if (adv) begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      fs_q     <= fs_d;
    end else begin
      fs_q     <= 1'b0;
    end
  end

  assign vga_o.hc          = hc_q;
  assign vga_o.vc          = vc_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.active      = active_q;
  assign vga_o.frame_start = fs_q;

endmodule
